// File: rtl/ifu_fetch.sv
// Instruction fetch stage: PC generation, imem request/response tracking, fetch queue and output register.
// Optional bubble counter on ifu_stall_cnt is built only when IFU_PERF_CNT_EN is defined.
module ifu_fetch #(
  parameter int unsigned          DataWidth = 32,
  parameter int unsigned          FifoDepth = 2,
  parameter logic [DataWidth-1:0] ResetPc   = '0,
  parameter logic [DataWidth-1:0] NopInst   = 32'h0000_0013
) (
  input  logic                 brq_clk,
  input  logic                 brq_rst,
  input  logic                 idu_flush,
  input  logic [1:0]           idu_next_pc_sel,
  input  logic                 idu_branch,
  input  logic [DataWidth-1:0] idu_branch_addr,
  input  logic [DataWidth-1:0] idu_jal_addr,
  input  logic [DataWidth-1:0] idu_jalr_addr,
  input  logic                 hazard_stall,
  output logic                 imem_req,
  output logic [DataWidth-1:0] imem_addr,
  input  logic                 imem_gnt,
  input  logic                 imem_rvalid,
  input  logic [DataWidth-1:0] imem_rdata,
  output logic [DataWidth-1:0] ifu_fetch_inst,
  output logic [DataWidth-1:0] ifu_pc,
  output logic                 ifu_stall,
  output logic [31:0]          ifu_stall_cnt
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned SumW = CntW + 1;

  logic [DataWidth-1:0] fetch_pc_q, fetch_pc_d;
  logic [CntW-1:0]      outstanding_q, outstanding_d;
  logic [CntW-1:0]      drop_q, drop_d;
  logic [CntW-1:0]      q_cnt_q, q_cnt_d;
  logic [PtrW-1:0]      q_wr_q, q_wr_d, q_rd_q, q_rd_d;
  logic [CntW-1:0]      tag_cnt_q, tag_cnt_d;
  logic [PtrW-1:0]      tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [DataWidth-1:0] inst_q, inst_d;
  logic [DataWidth-1:0] pc_q, pc_d;
  logic                 stall_q, stall_d;

  logic [DataWidth-1:0] q_inst_mem [FifoDepth];
  logic [DataWidth-1:0] q_pc_mem   [FifoDepth];
  logic [DataWidth-1:0] tag_mem    [FifoDepth];

  logic                 redirect;
  logic [DataWidth-1:0] redirect_pc;
  logic                 gnt_fire;
  logic                 rsp_keep;
  logic                 q_push, q_pop, tag_push, tag_pop;
  logic [SumW-1:0]      in_flight;

  always_comb begin
    redirect    = 1'b0;
    redirect_pc = fetch_pc_q;
    if (idu_flush) begin
      unique case (idu_next_pc_sel)
        2'b01: begin redirect = idu_branch; redirect_pc = idu_branch_addr; end
        2'b10: begin redirect = 1'b1;       redirect_pc = idu_jal_addr;    end
        2'b11: begin redirect = 1'b1;       redirect_pc = idu_jalr_addr;   end
        default: ;
      endcase
    end
  end

  assign in_flight = {1'b0, outstanding_q} + {1'b0, q_cnt_q};
  assign imem_req  = !brq_rst && !redirect && (in_flight < SumW'(FifoDepth));
  assign imem_addr = fetch_pc_q;
  assign gnt_fire  = imem_req && imem_gnt;
  // Responses landing in a redirect cycle are discarded outright rather than counted in drop.
  assign rsp_keep  = imem_rvalid && !redirect && (drop_q == '0);

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + CntW'(gnt_fire) - CntW'(imem_rvalid);
    drop_d        = drop_q;
    q_cnt_d       = q_cnt_q;
    q_wr_d        = q_wr_q;
    q_rd_d        = q_rd_q;
    tag_cnt_d     = tag_cnt_q;
    tag_wr_d      = tag_wr_q;
    tag_rd_d      = tag_rd_q;
    inst_d        = inst_q;
    pc_d          = pc_q;
    stall_d       = stall_q;
    q_push        = 1'b0;
    q_pop         = 1'b0;
    tag_push      = gnt_fire;
    tag_pop       = rsp_keep;

    if (gnt_fire) fetch_pc_d = fetch_pc_q + DataWidth'(4);

    if (redirect) begin
      fetch_pc_d = redirect_pc;
      drop_d     = outstanding_q - CntW'(imem_rvalid);
      tag_push   = 1'b0;
      tag_pop    = 1'b0;
      inst_d     = NopInst;
      stall_d    = 1'b1;
      q_cnt_d    = '0;
      q_wr_d     = '0;
      q_rd_d     = '0;
      tag_cnt_d  = '0;
      tag_wr_d   = '0;
      tag_rd_d   = '0;
    end else begin
      if (imem_rvalid && (drop_q != '0)) drop_d = drop_q - CntW'(1);
      if (hazard_stall) begin
        q_push = rsp_keep;
      end else if (q_cnt_q != '0) begin
        q_pop   = 1'b1;
        q_push  = rsp_keep;
        inst_d  = q_inst_mem[q_rd_q];
        pc_d    = q_pc_mem[q_rd_q];
        stall_d = 1'b0;
      end else if (rsp_keep) begin
        // Empty queue: the response bypasses straight into the output register.
        inst_d  = imem_rdata;
        pc_d    = tag_mem[tag_rd_q];
        stall_d = 1'b0;
      end else begin
        inst_d  = NopInst;
        stall_d = 1'b1;
      end
      if (q_push)   q_wr_d   = q_wr_q + PtrW'(1);
      if (q_pop)    q_rd_d   = q_rd_q + PtrW'(1);
      if (tag_push) tag_wr_d = tag_wr_q + PtrW'(1);
      if (tag_pop)  tag_rd_d = tag_rd_q + PtrW'(1);
      q_cnt_d   = q_cnt_q + CntW'(q_push) - CntW'(q_pop);
      tag_cnt_d = tag_cnt_q + CntW'(tag_push) - CntW'(tag_pop);
    end
  end

  always_ff @(posedge brq_clk) begin
    if (brq_rst) begin
      fetch_pc_q    <= ResetPc;
      outstanding_q <= '0;
      drop_q        <= '0;
      q_cnt_q       <= '0;
      q_wr_q        <= '0;
      q_rd_q        <= '0;
      tag_cnt_q     <= '0;
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
      inst_q        <= NopInst;
      pc_q          <= '0;
      stall_q       <= 1'b1;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      q_cnt_q       <= q_cnt_d;
      q_wr_q        <= q_wr_d;
      q_rd_q        <= q_rd_d;
      tag_cnt_q     <= tag_cnt_d;
      tag_wr_q      <= tag_wr_d;
      tag_rd_q      <= tag_rd_d;
      inst_q        <= inst_d;
      pc_q          <= pc_d;
      stall_q       <= stall_d;
    end
  end

  always_ff @(posedge brq_clk) begin
    if (q_push) begin
      q_inst_mem[q_wr_q] <= imem_rdata;
      q_pc_mem[q_wr_q]   <= tag_mem[tag_rd_q];
    end
    if (tag_push) tag_mem[tag_wr_q] <= fetch_pc_q;
  end

  assign ifu_fetch_inst = inst_q;
  assign ifu_pc         = pc_q;
  assign ifu_stall      = stall_q;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        bubble_load;

  always_comb begin
    bubble_load = redirect || (!hazard_stall && (q_cnt_q == '0) && !rsp_keep);
    stall_cnt_d = stall_cnt_q;
    if (bubble_load && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge brq_clk) begin
    if (brq_rst) stall_cnt_q <= '0;
    else         stall_cnt_q <= stall_cnt_d;
  end

  assign ifu_stall_cnt = stall_cnt_q;
`else
  assign ifu_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: memory model echoes the request address as the instruction word.
module tb_ifu_fetch;
  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        idu_flush;
  logic [1:0]  idu_next_pc_sel;
  logic        idu_branch;
  logic [31:0] idu_branch_addr, idu_jal_addr, idu_jalr_addr;
  logic        hazard_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] ifu_fetch_inst, ifu_pc, ifu_stall_cnt;
  logic        ifu_stall;

  int unsigned vec  = 0;
  int unsigned miss = 0;
  logic [31:0] exp_pc;

  logic [31:0] mem_q[$];
  int          out_cnt;
  logic        resp_hold;

  always #5 clk = ~clk;

  ifu_fetch #(.DataWidth(32), .FifoDepth(2), .ResetPc(32'h0), .NopInst(Nop)) dut (
    .brq_clk(clk), .brq_rst(rst),
    .idu_flush(idu_flush), .idu_next_pc_sel(idu_next_pc_sel), .idu_branch(idu_branch),
    .idu_branch_addr(idu_branch_addr), .idu_jal_addr(idu_jal_addr), .idu_jalr_addr(idu_jalr_addr),
    .hazard_stall(hazard_stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ifu_fetch_inst(ifu_fetch_inst), .ifu_pc(ifu_pc), .ifu_stall(ifu_stall),
    .ifu_stall_cnt(ifu_stall_cnt)
  );

  // In-order memory: a grant is answered in the following cycle unless resp_hold is set.
  always @(posedge clk) begin
    if (rst) begin
      mem_q.delete();
      out_cnt     <= 0;
      imem_rvalid <= 1'b0;
      imem_rdata  <= '0;
    end else begin
      if (imem_rvalid) void'(mem_q.pop_front());
      if (imem_req && imem_gnt) mem_q.push_back(imem_addr);
      out_cnt <= out_cnt + ((imem_req && imem_gnt) ? 1 : 0) - (imem_rvalid ? 1 : 0);
      if (!resp_hold && mem_q.size() > 0) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= mem_q[0];
      end else begin
        imem_rvalid <= 1'b0;
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; idu_flush = 1'b0; idu_next_pc_sel = 2'b00; idu_branch = 1'b0;
    idu_branch_addr = '0; idu_jal_addr = '0; idu_jalr_addr = '0;
    hazard_stall = 1'b0; imem_gnt = 1'b1; resp_hold = 1'b0;
    repeat (3) step();
    vec++; if (ifu_fetch_inst !== Nop) begin miss++; $display("FAIL reset_inst: got %h want %h", ifu_fetch_inst, Nop); end
    vec++; if (ifu_pc !== 32'h0) begin miss++; $display("FAIL reset_pc: got %h want 0", ifu_pc); end
    vec++; if (ifu_stall !== 1'b1) begin miss++; $display("FAIL reset_stall: got %b want 1", ifu_stall); end
    vec++; if (imem_req !== 1'b0) begin miss++; $display("FAIL reset_req: got %b want 0", imem_req); end
    vec++; if (ifu_stall_cnt !== 32'h0) begin miss++; $display("FAIL reset_cnt: got %0d want 0", ifu_stall_cnt); end
    rst = 1'b0;
    #1;
    vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      miss++; $display("FAIL first_req: req %b addr %h want 1 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    step();
    vec++; if (ifu_stall !== 1'b1) begin miss++; $display("FAIL latency_bubble: stall %b want 1", ifu_stall); end
    for (int k = 0; k < 3; k++) begin
      step();
      vec++; if (ifu_stall !== 1'b0 || ifu_pc !== 32'(4*k) || ifu_fetch_inst !== 32'(4*k)) begin
        miss++; $display("FAIL seq_%0d: stall %b pc %h inst %h want 0 %h %h", k, ifu_stall, ifu_pc, ifu_fetch_inst, 32'(4*k), 32'(4*k));
      end
    end
    exp_pc = 32'd12;
  endtask

  task automatic test_hazard();
    hazard_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vec++; if (ifu_stall !== 1'b0 || ifu_pc !== 32'd8 || ifu_fetch_inst !== 32'd8) begin
        miss++; $display("FAIL hazard_hold_%0d: stall %b pc %h inst %h want 0 8 8", i, ifu_stall, ifu_pc, ifu_fetch_inst);
      end
      vec++; if (out_cnt > 2) begin miss++; $display("FAIL hazard_outstanding: got %0d want <=2", out_cnt); end
    end
    hazard_stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vec++; if (ifu_stall !== 1'b0 || ifu_pc !== exp_pc || ifu_fetch_inst !== exp_pc) begin
        miss++; $display("FAIL hazard_release_%0d: stall %b pc %h inst %h want 0 %h %h", i, ifu_stall, ifu_pc, ifu_fetch_inst, exp_pc, exp_pc);
      end
      exp_pc += 32'd4;
    end
  endtask

  task automatic test_branch_not_taken();
    idu_flush = 1'b1; idu_next_pc_sel = 2'b01; idu_branch = 1'b0;
    idu_branch_addr = 32'h200; idu_jal_addr = 32'h300; idu_jalr_addr = 32'h400;
    #1;
    vec++; if (imem_req !== 1'b1) begin miss++; $display("FAIL nt_req: got %b want 1", imem_req); end
    for (int i = 0; i < 4; i++) begin
      step();
      idu_flush = 1'b0; idu_next_pc_sel = 2'b00;
      vec++; if (ifu_stall !== 1'b0 || ifu_pc !== exp_pc || ifu_fetch_inst !== exp_pc) begin
        miss++; $display("FAIL nt_seq_%0d: stall %b pc %h inst %h want 0 %h %h", i, ifu_stall, ifu_pc, ifu_fetch_inst, exp_pc, exp_pc);
      end
      exp_pc += 32'd4;
    end
  endtask

  task automatic test_gnt_hold();
    logic [31:0] a, c0, want_cnt;
    int unsigned b;
    bit          done;
    c0 = ifu_stall_cnt; b = 0; done = 1'b0;
    imem_gnt = 1'b0;
    #1 a = imem_addr;
    for (int i = 0; i < 4; i++) begin
      vec++; if (imem_req !== 1'b1 || imem_addr !== a) begin
        miss++; $display("FAIL gnt_hold_%0d: req %b addr %h want 1 %h", i, imem_req, imem_addr, a);
      end
      step();
      if (ifu_stall) b++;
      else begin
        vec++; if (ifu_pc !== exp_pc) begin miss++; $display("FAIL gnt_hold_pc: got %h want %h", ifu_pc, exp_pc); end
        exp_pc += 32'd4;
      end
    end
    imem_gnt = 1'b1;
    for (int i = 0; i < 10 && !done; i++) begin
      step();
      if (ifu_stall) b++;
      else begin
        done = 1'b1;
        vec++; if (ifu_pc !== exp_pc || ifu_fetch_inst !== exp_pc) begin
          miss++; $display("FAIL gnt_resume: pc %h inst %h want %h", ifu_pc, ifu_fetch_inst, exp_pc);
        end
        exp_pc += 32'd4;
      end
    end
    vec++; if (!done) begin miss++; $display("FAIL gnt_resume_timeout: got none want pc %h", exp_pc); end
    vec++; if (b < 2) begin miss++; $display("FAIL gnt_bubbles: got %0d want >=2", b); end
`ifdef IFU_PERF_CNT_EN
    want_cnt = c0 + b;
`else
    want_cnt = 32'h0;
`endif
    vec++; if (ifu_stall_cnt !== want_cnt) begin miss++; $display("FAIL stall_cnt: got %0d want %0d", ifu_stall_cnt, want_cnt); end
  endtask

  task automatic test_redirect_jal();
    bit ok = 1'b0;
    int unsigned seen = 0;
    resp_hold = 1'b1;
    for (int i = 0; i < 10 && !ok; i++) begin
      step();
      if (!ifu_stall) begin
        vec++; if (ifu_pc !== exp_pc) begin miss++; $display("FAIL jal_pre_pc: got %h want %h", ifu_pc, exp_pc); end
        exp_pc += 32'd4;
      end
      if (out_cnt == 2) ok = 1'b1;
    end
    vec++; if (!ok) begin miss++; $display("FAIL jal_outstanding_timeout: got %0d want 2", out_cnt); end
    idu_flush = 1'b1; idu_next_pc_sel = 2'b10; idu_jal_addr = 32'h100;
    #1;
    vec++; if (imem_req !== 1'b0) begin miss++; $display("FAIL jal_req_blocked: got %b want 0", imem_req); end
    step();
    idu_flush = 1'b0; idu_next_pc_sel = 2'b00; resp_hold = 1'b0;
    vec++; if (ifu_stall !== 1'b1 || ifu_fetch_inst !== Nop) begin
      miss++; $display("FAIL jal_bubble: stall %b inst %h want 1 %h", ifu_stall, ifu_fetch_inst, Nop);
    end
    exp_pc = 32'h100;
    for (int i = 0; i < 20 && seen < 3; i++) begin
      step();
      if (!ifu_stall) begin
        vec++; if (ifu_pc !== exp_pc || ifu_fetch_inst !== exp_pc) begin
          miss++; $display("FAIL jal_target_%0d: pc %h inst %h want %h", seen, ifu_pc, ifu_fetch_inst, exp_pc);
        end
        exp_pc += 32'd4; seen++;
      end
    end
    vec++; if (seen < 3) begin miss++; $display("FAIL jal_timeout: got %0d want 3 instructions", seen); end
  endtask

  task automatic test_jalr_wrap();
    int unsigned seen = 0;
    idu_flush = 1'b1; idu_next_pc_sel = 2'b11; idu_jalr_addr = 32'hFFFF_FFFC;
    step();
    idu_flush = 1'b0; idu_next_pc_sel = 2'b00;
    exp_pc = 32'hFFFF_FFFC;
    for (int i = 0; i < 20 && seen < 3; i++) begin
      step();
      if (!ifu_stall) begin
        vec++; if (ifu_pc !== exp_pc || ifu_fetch_inst !== exp_pc) begin
          miss++; $display("FAIL wrap_%0d: pc %h inst %h want %h", seen, ifu_pc, ifu_fetch_inst, exp_pc);
        end
        exp_pc += 32'd4; seen++;
      end
    end
    vec++; if (seen < 3) begin miss++; $display("FAIL wrap_timeout: got %0d want 3 instructions", seen); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_hazard();
    test_branch_not_taken();
    test_gnt_hold();
    test_redirect_jal();
    test_jalr_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
